// File: rtl/simon_pkg.sv
// simon_pkg: shared Simon game types, colour decoding and playback speed table
//   color_t          : 2-bit LED colour code (GREEN, YELLOW, RED, BLUE)
//   color_onehot()   : colour code -> one-hot LED drive [0] G .. [3] B
//   playback_state_t : sequence playback FSM states (FLASH only with SEQ_PLAYBACK_FINAL_FLASH_EN)
//   SPEED_SHIFT      : right-shift applied to the base on-time for each speed key value
package simon_pkg;
    typedef enum logic [1:0] {GREEN, YELLOW, RED, BLUE} color_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_RDWAIT, ST_ON, ST_GAP,
`ifdef SEQ_PLAYBACK_FINAL_FLASH_EN
        ST_FLASH,
`endif
        ST_DONE
    } playback_state_t;
    localparam logic [1:0] SPEED_SHIFT [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    function automatic logic [3:0] color_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler, one-cycle o_tick every TICK_CYCLES clocks
//   i_clk     : system clock, posedge
//   i_reset_n : asynchronous active-low reset
//   i_clear   : synchronous restart, the next cycle counts as the first of a new tick period
//   o_tick    : 1-cycle pulse on the last cycle of each period
module ms_tick_gen #(
    parameter int TICK_CYCLES = 200000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);
    localparam int W = $clog2(TICK_CYCLES + 1);
    logic [W-1:0] cnt;
    assign o_tick = cnt == W'(TICK_CYCLES - 1);
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt <= '0;
        else cnt <= (i_clear || o_tick) ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/sequence_playback_ctrl.sv
// sequence_playback_ctrl: plays the stored Simon colour sequence on the four LEDs once per round
//   i_clk, i_reset_n : clock (posedge) and asynchronous active-low reset
//   i_start          : launch pulse, honoured only when idle
//   i_abort          : level, returns to idle with LEDs off and no done pulse
//   i_length, i_speed: colours to play (clamped to MAX_LEN) and speed key, captured at start
//   o_rd_addr        : sequence memory address, i_rd_color returns its colour one cycle later
//   o_led_color      : registered one-hot LED drive
//   o_busy, o_done   : busy outside idle, 1-cycle pulse on completion
// Optional macro SEQ_PLAYBACK_FINAL_FLASH_EN adds an all-LEDs flash after the last colour.
module sequence_playback_ctrl
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int TICK_CYCLES = 200000,
    parameter int ON_BASE_MS  = 800
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [5:0]                 i_length,
    input  logic [1:0]                 i_speed,
    output logic [$clog2(MAX_LEN)-1:0] o_rd_addr,
    input  logic [1:0]                 i_rd_color,
    output logic [3:0]                 o_led_color,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int AW = $clog2(MAX_LEN);
    playback_state_t state;
    logic [AW-1:0] idx;
    logic [5:0] len_q;
    logic [10:0] on_ms, gap_ms, dur, target;
    logic tick, timing, tick_last, last;
    assign o_rd_addr = idx;
    always_comb begin
        gap_ms = on_ms >> 1;
`ifdef SEQ_PLAYBACK_FINAL_FLASH_EN
        timing = state == ST_ON || state == ST_GAP || state == ST_FLASH;
`else
        timing = state == ST_ON || state == ST_GAP;
`endif
        target = (state == ST_GAP) ? gap_ms : on_ms;
        tick_last = tick && dur == target - 11'd1;
        last = 6'(idx) + 6'd1 == len_q;
    end
    // The prescaler is held cleared outside timed states and restarted at each timed-state
    // change, so every ON/GAP/FLASH period is an exact multiple of TICK_CYCLES.
    ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_clear  (!timing || tick_last),
        .o_tick   (tick)
    );
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            len_q       <= '0;
            on_ms       <= '0;
            dur         <= '0;
            o_led_color <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else if (i_abort) begin
            state       <= ST_IDLE;
            idx         <= '0;
            dur         <= '0;
            o_led_color <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            dur    <= (timing && !tick_last) ? dur + {10'd0, tick} : '0;
            case (state)
                ST_IDLE: if (i_start) begin
                    len_q  <= (i_length > 6'(MAX_LEN)) ? 6'(MAX_LEN) : i_length;
                    on_ms  <= 11'(ON_BASE_MS) >> SPEED_SHIFT[i_speed];
                    idx    <= '0;
                    o_busy <= 1'b1;
                    state  <= (i_length == 6'd0) ? ST_DONE : ST_FETCH;
                end
                ST_FETCH: state <= ST_RDWAIT;
                ST_RDWAIT: begin
                    o_led_color <= color_onehot(color_t'(i_rd_color));
                    state       <= ST_ON;
                end
                // A zero-length gap (fastest speed, short base time) skips GAP entirely.
                ST_ON, ST_GAP: if (tick_last) begin
                    o_led_color <= '0;
                    if (state == ST_ON && gap_ms != 11'd0) state <= ST_GAP;
                    else if (last) begin
`ifdef SEQ_PLAYBACK_FINAL_FLASH_EN
                        o_led_color <= 4'b1111;
                        state       <= ST_FLASH;
`else
                        state       <= ST_DONE;
`endif
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= ST_FETCH;
                    end
                end
`ifdef SEQ_PLAYBACK_FINAL_FLASH_EN
                ST_FLASH: if (tick_last) begin
                    o_led_color <= '0;
                    state       <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    idx    <= '0;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_playback_ctrl.sv
// tb_sequence_playback_ctrl: randomized self-checking bench against a per-cycle expected timeline
module tb_sequence_playback_ctrl;
    localparam int TICK = 4;
    localparam int BASE = 8;
    localparam int MAXL = 32;
    typedef struct {
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic       chk_addr;
        logic [4:0] addr;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [5:0] i_length = '0;
    logic [1:0] i_speed = '0;
    logic [4:0] o_rd_addr;
    logic [1:0] rd_color = '0;
    logic [3:0] o_led_color;
    logic       o_busy;
    logic       o_done;
    logic [1:0] mem [MAXL];
    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    always #5 clk = ~clk;
    always @(posedge clk) rd_color <= mem[o_rd_addr];
    sequence_playback_ctrl #(.MAX_LEN(MAXL), .TICK_CYCLES(TICK), .ON_BASE_MS(BASE)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_length   (i_length),
        .i_speed    (i_speed),
        .o_rd_addr  (o_rd_addr),
        .i_rd_color (rd_color),
        .o_led_color(o_led_color),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic push(input logic [3:0] led, input logic busy, input logic done,
                        input logic ca, input int addr);
        exp_t e;
        e.led = led; e.busy = busy; e.done = done; e.chk_addr = ca; e.addr = 5'(addr);
        q.push_back(e);
    endtask
    // Timeline of the cycles after the start cycle: per colour two dark cycles (address, read),
    // on-time, half on-time gap; then optional all-on flash, one busy cycle, and the done cycle.
    task automatic build_stream(input int len, input int spd);
        int n = (len > MAXL) ? MAXL : len;
        int on_ms = BASE >> spd;
        int on_c = on_ms * TICK;
        int gap_c = (on_ms / 2) * TICK;
        q.delete();
        if (n == 0) begin
            push(4'h0, 1'b1, 1'b0, 1'b1, 0);
            push(4'h0, 1'b0, 1'b1, 1'b1, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            push(4'h0, 1'b1, 1'b0, 1'b1, k);
            push(4'h0, 1'b1, 1'b0, 1'b0, 0);
            repeat (on_c) push(4'b0001 << mem[k], 1'b1, 1'b0, 1'b0, 0);
            repeat (gap_c) push(4'h0, 1'b1, 1'b0, 1'b0, 0);
        end
`ifdef SEQ_PLAYBACK_FINAL_FLASH_EN
        repeat (on_c) push(4'hF, 1'b1, 1'b0, 1'b0, 0);
`endif
        push(4'h0, 1'b1, 1'b0, 1'b0, 0);
        push(4'h0, 1'b0, 1'b1, 1'b0, 0);
    endtask
    task automatic rand_mem();
        for (int k = 0; k < MAXL; k++) mem[k] = 2'($urandom_range(0, 3));
    endtask
    task automatic check_idle(input int cycles);
        repeat (cycles) begin
            chk("idle_led", o_led_color, 4'h0);
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_done", o_done, 1'b0);
            @(posedge clk); #1;
        end
    endtask
    task automatic play(input int len, input int spd, input int abort_at, input int reset_at);
        build_stream(len, spd);
        i_length = 6'(len);
        i_speed  = 2'(spd);
        i_start  = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int t = 0; t < q.size(); t++) begin
            chk("led", o_led_color, q[t].led);
            chk("busy", o_busy, q[t].busy);
            chk("done", o_done, q[t].done);
            if (q[t].chk_addr) chk("rd_addr", o_rd_addr, q[t].addr);
            if (t == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_led", o_led_color, 4'h0);
                chk("rst_busy", o_busy, 1'b0);
                chk("rst_done", o_done, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                break;
            end
            if (t == abort_at) begin
                i_abort = 1'b1;
                @(posedge clk); #1;
                i_abort = 1'b0;
                chk("abort_led", o_led_color, 4'h0);
                chk("abort_busy", o_busy, 1'b0);
                chk("abort_done", o_done, 1'b0);
                break;
            end
            i_start = q[t].busy && ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        check_idle(4);
    endtask
    initial begin
        int on_c, gap_c;
        rand_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", o_led_color, 4'h0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_done", o_done, 1'b0);
        chk("reset_addr", o_rd_addr, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        play(3, 0, -1, -1);
        rand_mem();
        play(2, 3, -1, -1);
        play(0, 1, -1, -1);
        play(50, 2, -1, -1);
        on_c = (BASE >> 0) * TICK;
        gap_c = (BASE >> 1) * TICK;
        play(4, 0, (2 + on_c + gap_c) + 2 + $urandom_range(0, on_c - 1), -1);
        i_start = 1'b1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        check_idle(6);
        play(3, 1, -1, 2 + (BASE >> 1) * TICK + $urandom_range(0, (BASE >> 2) * TICK - 1));
        rand_mem();
        play(5, 0, -1, -1);
        play(1, 0, -1, -1);
        repeat (6) begin
            rand_mem();
            play($urandom_range(0, 40), $urandom_range(0, 3), -1, -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
